// File: rtl/fifo_fwft_mbank.sv
// Purpose: first-word-fall-through sync FIFO, storage split into NUM_BANKS round-robin banks.
// Latency: word written at edge N is on rdata_o from edge N; flags follow registered count.
// Backpressure: writes refused while full (ovf_o), reads refused while empty (udf_o).
module fifo_fwft_mbank #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int NUM_BANKS  = 4,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
   parameter int AEMPTY_TH  = 4,
   parameter int AFULL_TH   = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  wen_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  full_o,
   output logic                  afull_o,
   input  logic                  ren_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  empty_o,
   output logic                  aempty_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  ovf_o,
   output logic                  udf_o
);

   localparam int BANK_DEPTH = FIFO_DEPTH / NUM_BANKS;
   localparam int BSEL_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int ROW_W      = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int PTR_W      = ADDR_WIDTH + 1;

   // Parameter sanity, caught at elaboration
   if (FIFO_DEPTH % NUM_BANKS != 0) begin : g_err_div
      $error("FIFO_DEPTH must be a multiple of NUM_BANKS");
   end
   if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_err_nb
      $error("NUM_BANKS must be a power of 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
      $error("FIFO_DEPTH must be a power of 2");
   end
   if (AFULL_TH > FIFO_DEPTH) begin : g_err_afull
      $error("AFULL_TH must not exceed FIFO_DEPTH");
   end

   logic [PTR_W-1:0]      waddr, raddr;
   logic [PTR_W-1:0]      count;
   logic                  ovf, udf;
   logic                  wr_acc, rd_acc;
   logic [BSEL_W-1:0]     wbank, rbank;
   logic [ROW_W-1:0]      wrow, rrow;
   logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];
   logic [DATA_WIDTH-1:0] head;

   // Pointer MSBs only carry the wrap lap; occupancy comes from the count register
   logic unused_ptr_msb;
   assign unused_ptr_msb = waddr[ADDR_WIDTH] ^ raddr[ADDR_WIDTH];

   // Low pointer bits pick the bank, the bits above pick the row inside it
   if (NUM_BANKS > 1) begin : g_bsel
      assign wbank = waddr[BSEL_W-1:0];
      assign rbank = raddr[BSEL_W-1:0];
   end else begin : g_bsel_one
      assign wbank = '0;
      assign rbank = '0;
   end

   if (BANK_DEPTH > 1) begin : g_row
      assign wrow = waddr[ADDR_WIDTH-1 -: ROW_W];
      assign rrow = raddr[ADDR_WIDTH-1 -: ROW_W];
   end else begin : g_row_one
      assign wrow = '0;
      assign rrow = '0;
   end

   // Flush dominates both requests; full/empty come from the registered count
   assign wr_acc = wen_i & ~full_o  & ~flush_i;
   assign rd_acc = ren_i & ~empty_o & ~flush_i;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];

      // Single write port per bank; only the bank under waddr is written
      always_ff @(posedge clk) begin
         if (wr_acc && wbank == BSEL_W'(b)) begin
            mem[wrow] <= wdata_i;
         end
      end

      assign bank_q[b] = mem[rrow];
   end

   // Head-of-queue mux over the bank outputs
   always_comb begin
      head = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rbank == BSEL_W'(b)) begin
            head = bank_q[b];
         end
      end
   end

   // Pointers, occupancy and sticky error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waddr <= '0;
         raddr <= '0;
         count <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else if (flush_i) begin
         waddr <= '0;
         raddr <= '0;
         count <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         if (wr_acc) begin
            waddr <= waddr + PTR_W'(1);
         end
         if (rd_acc) begin
            raddr <= raddr + PTR_W'(1);
         end
         if (wr_acc && !rd_acc) begin
            count <= count + PTR_W'(1);
         end else if (rd_acc && !wr_acc) begin
            count <= count - PTR_W'(1);
         end
         if (wen_i && full_o) begin
            ovf <= 1'b1;
         end
         if (ren_i && empty_o) begin
            udf <= 1'b1;
         end
      end
   end

   assign count_o  = count;
   assign full_o   = (count == PTR_W'(FIFO_DEPTH));
   assign empty_o  = (count == '0);
   assign afull_o  = (count >= PTR_W'(AFULL_TH));
   assign aempty_o = (count <= PTR_W'(AEMPTY_TH));
   assign ovf_o    = ovf;
   assign udf_o    = udf;
   assign rdata_o  = empty_o ? '0 : head;

endmodule
